bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-port arbiter and initialiser for a single block RAM instance (one registered read port, one write port, read latency 1). After reset it zero-fills the RAM, then shares the RAM between two requesters (e.g. fetch and debug) with round-robin arbitration, one access per cycle. It sits between the requesters and the RAM. It owns every RAM control input.

## Interface
- data_bits, 32, RAM word width
- nr_entries, 256, RAM depth; addr_bits = $clog2(nr_entries) (localparam)
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request; held until acked
- wr0 / wr1  in  1  1 = write, 0 = read; sampled with req
- addr0 / addr1  in  addr_bits  access address
- wdata0 / wdata1  in  data_bits  write data
- ack0 / ack1  out  1  combinational grant, same cycle as req
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a read ack
- rdata  out  data_bits  shared read data, equal to ram_read_data
- init_done  out  1  high once zero-fill is complete
- ram_read_addr  out  addr_bits  to RAM read_addr
- ram_read_data  in  data_bits  from RAM read_data
- ram_wr_en  out  1  to RAM wr_en
- ram_write_addr  out  addr_bits  to RAM write_addr
- ram_write_data  out  data_bits  to RAM write_data

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with clear_ctr=0, last_grant=1, rvalid regs=0, init_done=0.
- CLEAR:
  - ram_wr_en=1, ram_write_addr=clear_ctr, ram_write_data=0.
  - clear_ctr increments each cycle. When clear_ctr==nr_entries-1, go to RUN next cycle and set init_done=1.
  - ack0/ack1=0 regardless of req.
- RUN, grant selection each cycle:
  - Only req0: grant 0. Only req1: grant 1.
  - Both: grant !last_grant.
  - Neither: no grant; last_grant holds.
  - last_grant updates to the granted port at the clock edge.
- Granted read: ram_read_addr=addr of granted port, ram_wr_en=0. rvalidN is registered high for exactly the next cycle.
- Granted write: ram_wr_en=1, ram_write_addr/ram_write_data from the granted port. No rvalid.
- No grant: ram_wr_en=0, ram_read_addr=0.
- At most one RAM access per cycle. The requesters never see a same-cycle read/write collision. A write at cycle T followed by a read of the same address at T+1 returns the new data.
- rdata is a pure pass-through. It is meaningful only when rvalidN=1.
- Reset in any state, including mid-CLEAR or with rvalid pending:
  - Return to CLEAR, restart clear_ctr at 0.
  - rvalid0/1=0 and init_done=0 from the next cycle.
  - The pending read is dropped.
- Width rules:
  - clear_ctr is addr_bits wide. The terminal compare is against nr_entries-1, so non-power-of-two depths stop early and never wrap.
  - nr_entries must be >= 2.

## Timing
- Reset values: init_done=0, rvalid0=0, rvalid1=0, ack0=ack1=0.
- After reset: ram_wr_en=1 with addr 0 in the first CLEAR cycle. The addr nr_entries-1 write occurs in CLEAR cycle nr_entries.
- init_done rises nr_entries cycles after rst deasserts. The first ack is possible in that same cycle.
- Ack latency: 0 cycles in RUN (combinational from req and state).
- Read data latency: 1 cycle after ack (rvalid and rdata together).
- Throughput:
  - One access per cycle total.
  - With both requesting continuously, grants alternate 0,1,0,1,...; port 0 wins the first contended cycle after reset.
  - A single continuously requesting port gets every cycle.

## Test plan
- Reset, nr_entries=8: ram_wr_en high for 8 cycles at addrs 0..7 with data 0. init_done rises after the 8th write. Req held during CLEAR gets no ack.
- Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 on the next cycle: ack0 on both cycles, rvalid0=1 with rdata=0xDEADBEEF one cycle after the read ack.
- Both ports read continuously (addr0=1, addr1=2, preloaded 0x11, 0x22): acks alternate starting with ack0. rvalid0 and rvalid1 alternate with rdata 0x11, 0x22.
- Port 1 alone reads for 4 cycles: ack1 every cycle and rvalid1 every cycle after the first. Then both request: port 0 is granted first.
- Read of never-written addr 3 after init: rdata=0.
- Assert rst on the cycle after a read ack: rvalid is 0 the next cycle, init_done drops, and the zero-fill restarts at addr 0.

Source files
------------

// File: rtl/bram_arbiter.sv
// bram_arbiter: zero-fills a single block RAM after reset, then shares it
// between two requesters with round-robin arbitration, one access per cycle.
// The RAM has one registered read port (latency 1) and one write port; this
// block drives every RAM control input.
//
// Handshake: a requester raises reqN with wrN/addrN/wdataN stable and holds
// them until ackN. ackN is combinational in the same cycle as the request and
// means the access is issued to the RAM in that cycle. For a read, rvalidN is
// high exactly one cycle later, and rdata carries the word in that cycle.
module bram_arbiter #(
  parameter int data_bits  = 32,
  parameter int nr_entries = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req0,
  input  logic                                 req1,
  input  logic                                 wr0,
  input  logic                                 wr1,
  input  logic [$clog2(nr_entries)-1:0]        addr0,
  input  logic [$clog2(nr_entries)-1:0]        addr1,
  input  logic [data_bits-1:0]                 wdata0,
  input  logic [data_bits-1:0]                 wdata1,
  output logic                                 ack0,
  output logic                                 ack1,
  output logic                                 rvalid0,
  output logic                                 rvalid1,
  output logic [data_bits-1:0]                 rdata,
  output logic                                 init_done,
  output logic [$clog2(nr_entries)-1:0]        ram_read_addr,
  input  logic [data_bits-1:0]                 ram_read_data,
  output logic                                 ram_wr_en,
  output logic [$clog2(nr_entries)-1:0]        ram_write_addr,
  output logic [data_bits-1:0]                 ram_write_data
);

  localparam int addr_bits = $clog2(nr_entries);
  // Terminal clear address; compared exactly so non-power-of-two depths
  // stop at the last real entry instead of wrapping.
  localparam logic [addr_bits-1:0] last_addr = addr_bits'(nr_entries - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                 state;
  logic [addr_bits-1:0]   clear_ctr;
  // Port that won the most recent grant; reset to 1 so port 0 wins the
  // first contended cycle.
  logic                   last_grant;

  logic                   grant0;
  logic                   grant1;
  logic                   sel_wr;
  logic [addr_bits-1:0]   sel_addr;
  logic [data_bits-1:0]   sel_wdata;

  // Round-robin grant: only possible in RUN; contention goes to the port
  // that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == RUN) begin
      if (req0 && req1) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Mux the granted port's command onto a single access.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant0) begin
      sel_wr    = wr0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end else if (grant1) begin
      sel_wr    = wr1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Drive the RAM: zero-fill writes during CLEAR, otherwise the single
  // granted access; idle cycles park the read address at 0.
  always_comb begin
    ram_wr_en      = 1'b0;
    ram_write_addr = '0;
    ram_write_data = '0;
    ram_read_addr  = '0;
    if (state == CLEAR) begin
      ram_wr_en      = 1'b1;
      ram_write_addr = clear_ctr;
      ram_write_data = '0;
    end else if (grant0 || grant1) begin
      if (sel_wr) begin
        ram_wr_en      = 1'b1;
        ram_write_addr = sel_addr;
        ram_write_data = sel_wdata;
      end else begin
        ram_read_addr  = sel_addr;
      end
    end
  end

  assign ack0  = grant0;
  assign ack1  = grant1;
  assign rdata = ram_read_data;

  // Controller state, clear counter, arbitration history and read-valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clear_ctr  <= '0;
      last_grant <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          if (clear_ctr == last_addr) begin
            clear_ctr <= '0;
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            clear_ctr <= clear_ctr + 1'b1;
          end
        end
        RUN: begin
          if (grant0) begin
            last_grant <= 1'b0;
          end else if (grant1) begin
            last_grant <= 1'b1;
          end
          rvalid0 <= grant0 && !wr0;
          rvalid1 <= grant1 && !wr1;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter with an 8-entry RAM model: zero-fill sequence,
// a table of RUN-mode cycles, and a reset-during-pending-read sequence.
module tb_bram_arbiter;

  localparam int dw = 32;
  localparam int ne = 8;
  localparam int aw = 3;

  logic          clk;
  logic          rst;
  logic          req0, req1, wr0, wr1;
  logic [aw-1:0] addr0, addr1;
  logic [dw-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1, init_done;
  logic [dw-1:0] rdata;
  logic [aw-1:0] ram_read_addr, ram_write_addr;
  logic [dw-1:0] ram_read_data, ram_write_data;
  logic          ram_wr_en;

  logic [dw-1:0] mem [ne];

  int n_cmp;
  int n_err;

  bram_arbiter #(.data_bits(dw), .nr_entries(ne)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .ram_wr_en(ram_wr_en), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block RAM model: registered read (old data on same-address write),
  // synchronous write.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_write_addr] <= ram_write_data;
    ram_read_data <= mem[ram_read_addr];
  end

  typedef struct {
    logic          r0, w0;
    logic [aw-1:0] a0;
    logic [dw-1:0] d0;
    logic          r1, w1;
    logic [aw-1:0] a1;
    logic [dw-1:0] d1;
    logic          e_ack0, e_ack1, e_wr;
    logic [aw-1:0] e_wa;
    logic [dw-1:0] e_wd;
    logic          e_rv0, e_rv1, chk_rd;
    logic [dw-1:0] e_rd;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    logic r0, logic w0, logic [aw-1:0] a0, logic [dw-1:0] d0,
    logic r1, logic w1, logic [aw-1:0] a1, logic [dw-1:0] d1,
    logic ea0, logic ea1, logic ewr, logic [aw-1:0] ewa, logic [dw-1:0] ewd,
    logic erv0, logic erv1, logic crd, logic [dw-1:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_wr = ewr; v.e_wa = ewa; v.e_wd = ewd;
    v.e_rv0 = erv0; v.e_rv1 = erv1; v.chk_rd = crd; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [dw-1:0] act, input logic [dw-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called right after rst is released at a negedge: checks the 8 zero-fill
  // writes, then init_done one cycle after the last one.
  task automatic clear_seq();
    for (int k = 0; k < ne; k++) begin
      #1;
      chk("clear_wr_en", 32'(ram_wr_en), 32'd1);
      chk("clear_waddr", 32'(ram_write_addr), 32'(k));
      chk("clear_wdata", ram_write_data, 32'd0);
      chk("clear_ack0", 32'(ack0), 32'd0);
      chk("clear_init_done", 32'(init_done), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("init_done_rise", 32'(init_done), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < ne; i++) mem[i] = 32'hBAD0_0000 | 32'(i);

    // Reset, with port 0 already requesting a read of addr 0
    rst = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    clear_seq();
    // First ack is possible in the cycle init_done rises
    chk("first_ack0", 32'(ack0), 32'd1);
    chk("first_raddr", 32'(ram_read_addr), 32'd0);

    // RUN-mode cycle table; rvalid/rdata columns refer to the previous row.
    tbl[0]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,          1,0,1,5,32'hDEADBEEF, 1,0,1,32'h0);
    tbl[1]  = mk(1,0,5,0,            0,0,0,0,          1,0,0,0,0,            0,0,0,0);
    tbl[2]  = mk(1,1,1,32'h11,       0,0,0,0,          1,0,1,1,32'h11,       1,0,1,32'hDEADBEEF);
    tbl[3]  = mk(0,0,0,0,            1,1,2,32'h22,     0,1,1,2,32'h22,       0,0,0,0);
    tbl[4]  = mk(1,0,1,0,            1,0,2,0,          1,0,0,0,0,            0,0,0,0);
    tbl[5]  = mk(1,0,1,0,            1,0,2,0,          0,1,0,0,0,            1,0,1,32'h11);
    tbl[6]  = mk(1,0,1,0,            1,0,2,0,          1,0,0,0,0,            0,1,1,32'h22);
    tbl[7]  = mk(1,0,1,0,            1,0,2,0,          0,1,0,0,0,            1,0,1,32'h11);
    tbl[8]  = mk(0,0,0,0,            1,0,2,0,          0,1,0,0,0,            0,1,1,32'h22);
    tbl[9]  = mk(0,0,0,0,            1,0,2,0,          0,1,0,0,0,            0,1,1,32'h22);
    tbl[10] = mk(0,0,0,0,            1,0,2,0,          0,1,0,0,0,            0,1,1,32'h22);
    tbl[11] = mk(0,0,0,0,            1,0,2,0,          0,1,0,0,0,            0,1,1,32'h22);
    tbl[12] = mk(1,0,3,0,            1,0,2,0,          1,0,0,0,0,            0,1,1,32'h22);
    tbl[13] = mk(0,0,0,0,            0,0,0,0,          0,0,0,0,0,            1,0,1,32'h0);
    tbl[14] = mk(0,0,0,0,            1,1,3,32'h33,     0,1,1,3,32'h33,       0,0,0,0);
    tbl[15] = mk(1,0,3,0,            1,0,2,0,          1,0,0,0,0,            0,0,0,0);
    tbl[16] = mk(0,0,0,0,            0,0,0,0,          0,0,0,0,0,            1,0,1,32'h33);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req0 = tbl[i].r0; wr0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; wr1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      #1;
      chk($sformatf("v%0d_ack0", i), 32'(ack0), 32'(tbl[i].e_ack0));
      chk($sformatf("v%0d_ack1", i), 32'(ack1), 32'(tbl[i].e_ack1));
      chk($sformatf("v%0d_wr_en", i), 32'(ram_wr_en), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].e_rv0));
      chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].e_rv1));
      if (tbl[i].e_wr) begin
        chk($sformatf("v%0d_waddr", i), 32'(ram_write_addr), 32'(tbl[i].e_wa));
        chk($sformatf("v%0d_wdata", i), ram_write_data, tbl[i].e_wd);
      end
      if (tbl[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rd);
      if (!tbl[i].e_ack0 && !tbl[i].e_ack1)
        chk($sformatf("v%0d_idle_raddr", i), 32'(ram_read_addr), 32'd0);
      else if (tbl[i].e_ack0 && !tbl[i].w0)
        chk($sformatf("v%0d_raddr", i), 32'(ram_read_addr), 32'(tbl[i].a0));
      else if (tbl[i].e_ack1 && !tbl[i].w1)
        chk($sformatf("v%0d_raddr", i), 32'(ram_read_addr), 32'(tbl[i].a1));
    end

    // Reset asserted the cycle after a read ack drops the pending read
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd5; req1 = 1'b0;
    #1;
    chk("rr_ack0", 32'(ack0), 32'd1);
    @(negedge clk);
    req0 = 1'b0; rst = 1'b1;
    #1;
    chk("rr_rvalid0_before", 32'(rvalid0), 32'd1);
    chk("rr_rdata_before", rdata, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    chk("rr_rvalid0_after", 32'(rvalid0), 32'd0);
    chk("rr_init_done_drop", 32'(init_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_seq();

    // Previously written addr 5 must read back zero after the refill
    req0 = 1'b1; wr0 = 1'b0; addr0 = 3'd5;
    #0;
    chk("refill_ack0", 32'(ack0), 32'd1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("refill_rvalid0", 32'(rvalid0), 32'd1);
    chk("refill_rdata", rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
